// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the system bus arbiter.
// Holds the owner index type, the master index constants, the arbiter
// state encoding and the active-low enable levels used on bus strobes.
package bus_arbiter_pkg;

    localparam int unsigned NUM_MASTERS = 4;
    localparam int unsigned OWNER_W     = 2;

    // Index of a bus master; also the width of the owner output.
    typedef logic [OWNER_W-1:0] BusOwnerBus;

    localparam BusOwnerBus BUS_OWNER_MASTER_0 = 2'd0;
    localparam BusOwnerBus BUS_OWNER_MASTER_1 = 2'd1;
    localparam BusOwnerBus BUS_OWNER_MASTER_2 = 2'd2;
    localparam BusOwnerBus BUS_OWNER_MASTER_3 = 2'd3;

    typedef enum logic {
        BUS_ARB_STATE_IDLE  = 1'b0,
        BUS_ARB_STATE_GRANT = 1'b1
    } BusArbStateBus;

    // Active-low strobe levels.
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

endpackage

// File: rtl/bus_arb_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req_i     active-high request vector, one bit per master
//   start_i   index searched first; the search wraps modulo NUM_MASTERS
//   winner_c  first requesting index at or after start_i
//   found_c   high when any request bit is set
module bus_arb_rr_pick
    import bus_arbiter_pkg::*;
(
    input  logic [NUM_MASTERS-1:0] req_i,
    input  BusOwnerBus             start_i,
    output BusOwnerBus             winner_c,
    output logic                   found_c
);

    BusOwnerBus idx;

    // Walk from the farthest offset down so the nearest requester is written last.
    always_comb begin
        winner_c = start_i;
        found_c  = 1'b0;
        idx      = start_i;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            idx = start_i + OWNER_W'(i);
            if (req_i[idx]) begin
                winner_c = idx;
                found_c  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared system bus with four masters.
// Grants change only at transaction boundaries seen on the muxed slave
// strobes; a tenure counter forces handover from a streaming owner.
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   m0_req_..m3_req_      active-low bus requests
//   s_as_, s_rdy_         muxed slave address strobe / ready (active-low)
//   m0_grnt_..m3_grnt_    active-low grants, one-hot-low or all-high
//   owner                 current or last granted master
//   busy                  high while any grant is asserted
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned TENURE_MAX = 16,
    parameter int unsigned TENURE_W   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       m0_req_,
    input  logic       m1_req_,
    input  logic       m2_req_,
    input  logic       m3_req_,
    input  logic       s_as_,
    input  logic       s_rdy_,
    output logic       m0_grnt_,
    output logic       m1_grnt_,
    output logic       m2_grnt_,
    output logic       m3_grnt_,
    output logic [1:0] owner,
    output logic       busy
);

    localparam logic [TENURE_W-1:0] TENURE_LAST = TENURE_W'(TENURE_MAX - 1);
    localparam logic [TENURE_W-1:0] TENURE_SAT  = {TENURE_W{1'b1}};

    BusArbStateBus          state_q, state_d;
    BusOwnerBus             owner_q, owner_d;
    logic [TENURE_W-1:0]    tenure_q, tenure_d;
    logic [NUM_MASTERS-1:0] grnt_q, grnt_d;
    logic                   busy_q, busy_d;

    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] req_pick;
    BusOwnerBus             pick_owner;
    logic                   pick_found;
    logic                   owner_req;
    logic                   bnd;
    logic                   expired;

    assign req = {m3_req_ == ENABLE_, m2_req_ == ENABLE_,
                  m1_req_ == ENABLE_, m0_req_ == ENABLE_};

    assign owner_req = req[owner_q];

    // While granted, only other masters are candidates; found then means "someone else waits".
    assign req_pick = (state_q == BUS_ARB_STATE_GRANT)
                    ? (req & ~(NUM_MASTERS'(1) << owner_q))
                    : req;

    assign bnd     = (s_as_ == DISABLE_) || (s_rdy_ == ENABLE_);
    assign expired = (TENURE_MAX != 0) && (tenure_q >= TENURE_LAST);

    bus_arb_rr_pick u_pick (
        .req_i    (req_pick),
        .start_i  (owner_q + OWNER_W'(1)),
        .winner_c (pick_owner),
        .found_c  (pick_found)
    );

    // Next-state: release beats preemption, preemption waits for a boundary.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        tenure_d = tenure_q;
        if (state_q == BUS_ARB_STATE_IDLE) begin
            if (pick_found) begin
                state_d  = BUS_ARB_STATE_GRANT;
                owner_d  = pick_owner;
                tenure_d = '0;
            end
        end else begin
            if (!owner_req) begin
                if (pick_found) begin
                    owner_d  = pick_owner;
                    tenure_d = '0;
                end else begin
                    state_d = BUS_ARB_STATE_IDLE;
                end
            end else if (expired && pick_found && bnd) begin
                owner_d  = pick_owner;
                tenure_d = '0;
            end else if (tenure_q != TENURE_SAT) begin
                tenure_d = tenure_q + TENURE_W'(1);
            end
        end
    end

    // Outputs are registered copies of the next-state decode, so they stay glitch-free.
    always_comb begin
        grnt_d = '1;
        busy_d = (state_d == BUS_ARB_STATE_GRANT);
        if (busy_d) begin
            grnt_d = ~(NUM_MASTERS'(1) << owner_d);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= BUS_ARB_STATE_IDLE;
            owner_q  <= BUS_OWNER_MASTER_3;
            tenure_q <= '0;
            grnt_q   <= '1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            tenure_q <= tenure_d;
            grnt_q   <= grnt_d;
            busy_q   <= busy_d;
        end
    end

    assign m0_grnt_ = grnt_q[0];
    assign m1_grnt_ = grnt_q[1];
    assign m2_grnt_ = grnt_q[2];
    assign m3_grnt_ = grnt_q[3];
    assign owner    = owner_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Testbench for bus_arbiter: behavioural model checked every cycle plus
// directed scenarios with literal expectations.
module tb_bus_arbiter;

    localparam int TMAX = 4;

    logic       clk;
    logic       reset;
    logic [3:0] req_n;
    logic       s_as_;
    logic       s_rdy_;
    logic       m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_;
    logic [1:0] owner;
    logic       busy;

    int total = 0;
    int bad   = 0;

    bus_arbiter #(.TENURE_MAX(TMAX), .TENURE_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .m0_req_  (req_n[0]),
        .m1_req_  (req_n[1]),
        .m2_req_  (req_n[2]),
        .m3_req_  (req_n[3]),
        .s_as_    (s_as_),
        .s_rdy_   (s_rdy_),
        .m0_grnt_ (m0_grnt_),
        .m1_grnt_ (m1_grnt_),
        .m2_grnt_ (m2_grnt_),
        .m3_grnt_ (m3_grnt_),
        .owner    (owner),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] gv;
    assign gv = {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_};

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_busy   = 0;
    int         m_owner  = 3;
    int         m_cycles = 0;    // cycles the current owner has held the bus
    logic [3:0] r_now;
    logic [3:0] others;
    int         w_now;
    logic [3:0] exp_gv;

    function automatic int pick(input logic [3:0] r, input int start);
        for (int k = 0; k < 4; k++) begin
            int n;
            n = (start + k) % 4;
            if (r[n]) return n;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy   = 0;
            m_owner  = 3;
            m_cycles = 0;
        end else begin
            r_now = ~req_n;
            if (m_busy == 0) begin
                w_now = pick(r_now, (m_owner + 1) % 4);
                if (w_now >= 0) begin
                    m_busy   = 1;
                    m_owner  = w_now;
                    m_cycles = 1;
                end
            end else begin
                others          = r_now;
                others[m_owner] = 1'b0;
                w_now           = pick(others, (m_owner + 1) % 4);
                if (!r_now[m_owner]) begin
                    if (w_now >= 0) begin
                        m_owner  = w_now;
                        m_cycles = 1;
                    end else begin
                        m_busy = 0;
                    end
                end else if (w_now >= 0 && TMAX != 0 && m_cycles >= TMAX && (s_as_ || !s_rdy_)) begin
                    m_owner  = w_now;
                    m_cycles = 1;
                end else begin
                    m_cycles++;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        exp_gv = (m_busy != 0) ? (4'hF ^ (4'b0001 << m_owner)) : 4'hF;
        chk("mdl_grnt", int'(gv), int'(exp_gv));
        chk("mdl_owner", int'(owner), m_owner);
        chk("mdl_busy", int'(busy), m_busy);
    end

    // ---------------- directed stimulus ----------------
    task automatic reset_pulse();
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
    endtask

    int order [5] = '{0, 1, 2, 3, 0};

    initial begin
        reset  = 1'b0;
        req_n  = 4'hF;
        s_as_  = 1'b1;
        s_rdy_ = 1'b1;

        // Reset state and single request from m2.
        @(negedge clk);
        chk("rst_grnt", int'(gv), 15);
        chk("rst_owner", int'(owner), 3);
        chk("rst_busy", int'(busy), 0);
        #2 reset = 1'b1;
        @(negedge clk);
        req_n[2] = 1'b0;
        @(negedge clk);
        chk("m2_grnt", int'(gv), 4'b1011);
        chk("m2_owner", int'(owner), 2);
        chk("m2_busy", int'(busy), 1);
        req_n = 4'hF;
        @(negedge clk);
        chk("m2_rel_grnt", int'(gv), 15);
        chk("m2_rel_owner", int'(owner), 2);

        // All four request; each owner releases after 3 cycles and re-requests.
        reset_pulse();
        req_n = 4'h0;
        @(negedge clk);
        for (int g = 0; g < 5; g++) begin
            for (int c = 0; c < 3; c++) begin
                chk("rr_owner", int'(owner), order[g]);
                chk("rr_busy", int'(busy), 1);
                if (c == 2) req_n[order[g]] = 1'b1;
                @(negedge clk);
                if (c == 2) req_n[order[g]] = 1'b0;
            end
        end
        req_n = 4'hF;
        @(negedge clk);
        @(negedge clk);

        // Tenure expiry with boundary always present.
        reset_pulse();
        req_n = 4'b1101;
        @(negedge clk);
        chk("ten_m1", int'(owner), 1);
        req_n[3] = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("ten_hold", int'(owner), 1);
        end
        @(negedge clk);
        chk("ten_handover", int'(owner), 3);
        chk("ten_grnt", int'(gv), 4'b0111);
        req_n = 4'hF;
        @(negedge clk);
        @(negedge clk);

        // Tenure expiry deferred by an access in progress.
        reset_pulse();
        s_as_  = 1'b0;
        s_rdy_ = 1'b1;
        req_n  = 4'b1101;
        @(negedge clk);
        chk("def_m1", int'(owner), 1);
        req_n[3] = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            chk("def_hold", int'(owner), 1);
        end
        s_rdy_ = 1'b0;
        @(negedge clk);
        chk("def_handover", int'(owner), 3);
        chk("def_grnt", int'(gv), 4'b0111);
        s_rdy_ = 1'b1;
        s_as_  = 1'b1;
        req_n  = 4'hF;
        @(negedge clk);
        @(negedge clk);

        // Release with nobody waiting, then m0+m1 together.
        reset_pulse();
        req_n = 4'b1110;
        @(negedge clk);
        chk("idl_m0", int'(owner), 0);
        @(negedge clk);
        req_n = 4'hF;
        @(negedge clk);
        chk("idl_grnt", int'(gv), 15);
        chk("idl_owner", int'(owner), 0);
        chk("idl_busy", int'(busy), 0);
        req_n = 4'b1100;
        @(negedge clk);
        chk("idl_next_owner", int'(owner), 1);
        chk("idl_next_grnt", int'(gv), 4'b1101);
        req_n = 4'hF;
        @(negedge clk);
        @(negedge clk);

        // Asynchronous reset while m3 owns the bus.
        reset_pulse();
        req_n = 4'b0111;
        @(negedge clk);
        chk("ar_m3", int'(owner), 3);
        chk("ar_m3_grnt", int'(m3_grnt_), 0);
        #2 reset = 1'b0;
        #1;
        chk("ar_drop", int'(m3_grnt_), 1);
        chk("ar_owner", int'(owner), 3);
        chk("ar_busy", int'(busy), 0);
        req_n = 4'b0110;
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        chk("ar_first", int'(owner), 0);
        chk("ar_first_grnt", int'(gv), 4'b1110);
        req_n = 4'hF;
        @(negedge clk);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter granting the shared system bus to one of four masters. It owns the `mN_grnt_` signals consumed by the bus master multiplexer and the read-data return path. A per-grant tenure counter stops a streaming master from starving the others. Handover occurs only at transaction boundaries, detected on the muxed slave-side strobe and ready.

## Interface
- `TENURE_MAX`, default 16: maximum grant cycles before forced handover when another master is waiting. A value of 0 disables preemption.
- `TENURE_W`, default 8: width of the tenure counter. Requires `TENURE_MAX < 2**TENURE_W`.
- `clk`  in  1  system clock. All state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `m0_req_` .. `m3_req_`  in  1 each  bus request from master N. Active-low (`ENABLE_`).
- `s_as_`  in  1  muxed address strobe on the slave side. Active-low.
- `s_rdy_`  in  1  muxed slave ready. Active-low. Low means the current access completes this cycle.
- `m0_grnt_` .. `m3_grnt_`  out  1 each  bus grant. Active-low, one-hot-low or all-high.
- `owner`  out  2  index of the current or last granted master.
- `busy`  out  1  high while any grant is asserted.

## Operation
- State register `state` is either `IDLE` or `GRANT`. Other registers:
  - `owner` (2 b)
  - `tenure` (`TENURE_W` b)
- Reset values:
  - `state` = `IDLE`
  - `owner` = 3, so master 0 has top priority after reset
  - `tenure` = 0
  - all `mN_grnt_` = 1
  - `busy` = 0
- Grant decode: `mN_grnt_` = 0 iff `state==GRANT && owner==N`. `busy` = `state==GRANT`. Both are decoded from registers only, so there is no combinational path from requests to grants.
- Round-robin pick: search requesters in order `owner+1`, `owner+2`, `owner+3`, `owner`, all mod 4. The first with `req_`=0 wins.
- Transaction boundary `bnd` = `s_as_==1 || s_rdy_==0`.
- Transitions in `IDLE`:
  - Any request present: go to `GRANT`, `owner` = pick, `tenure` = 0.
  - Otherwise: hold.
- Transitions in `GRANT`, evaluated in priority order:
  1. Owner `req_`=1 (release): if another request exists, `owner` = pick and `tenure` = 0, staying in `GRANT` (back-to-back handover, no idle cycle). Otherwise go to `IDLE` and keep `owner`.
  2. `TENURE_MAX`≠0, `tenure` ≥ `TENURE_MAX`-1, another master requesting, and `bnd`: preempt. `owner` = pick (never the current owner, since another requester exists), `tenure` = 0.
  3. Otherwise stay and increment `tenure`, saturating at all-ones.
- Preemption is deferred while `bnd`=0. The owner keeps the bus until its access completes.
- If release and tenure expiry coincide, release wins. The result is identical, so no special case is needed.
- `reset` asserted mid-grant: all grants drop immediately (asynchronously). The next arbitration starts from master 0.

## Timing
- Request to grant: 1 cycle. `req_` low at edge k gives `grnt_` low after edge k+1.
- Release to next grant: 1 cycle. The old owner's `grnt_` rises and the new `grnt_` falls on the same edge, so no two grants are ever low simultaneously.
- Release with no other requester: `grnt_` high 1 cycle after `req_` rises.
- Tenure: the owner holds at least `TENURE_MAX` cycles when contended, longer only while waiting for `bnd`.
- All outputs are glitch-free register decodes, valid from the cycle after the edge.

## Structure
- Add to `bus.h`:
  - `BusOwnerBus` (1:0)
  - `BUS_OWNER_MASTER_0`..`3`
  - `BUS_ARB_STATE_IDLE` / `BUS_ARB_STATE_GRANT`
  - `BusArbStateBus`
- Use existing `ENABLE_`/`DISABLE_` from `stddef.h`.
- Sub-module `bus_arb_rr_pick`, purely combinational:
  - inputs: 4-bit request vector (active-high), 2-bit start pointer
  - outputs: 2-bit winner, `found`
- `bus_arbiter` instantiates it once, with start pointer `owner+1` and the current owner's request masked out for preemption.

## Test plan
- Reset, then `m2_req_`=0 only: `m2_grnt_`=0 one cycle later, `owner`=2, `busy`=1. Other grants stay 1.
- From reset, all four requests asserted simultaneously: grant order is 0,1,2,3,0 as each owner releases after 3 cycles. Handover is back-to-back, with no all-high cycle between grants.
- `TENURE_MAX`=4: m1 holds `req_` low continuously with `s_as_`=1 and m3 requests. The m3 grant lands exactly 4 cycles after the m1 grant.
- Same setup with `s_as_`=0 and `s_rdy_`=1 for 6 more cycles: handover is deferred until the cycle after `s_rdy_`=0.
- m0 granted and releases with no other request: all grants high 1 cycle later, `owner` stays 0. A subsequent simultaneous m0+m1 request grants m1.
- `reset` pulsed low while m3 is granted: `m3_grnt_` rises asynchronously and `owner`=3. With m0 and m3 both requesting after reset, m0 is granted first.
